// File: rtl/can_rx_frame_ctrl_if.sv
// Bus between the CAN frame receive controller, its bit sampler and the frame consumer.
interface can_rx_frame_ctrl_if;
  logic        rx;
  logic        smp_en;
  logic        smp_bit;
  logic        smp_valid;
  logic [10:0] id;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        frame_valid;
  logic        frame_err;

  modport master (
    input  rx, smp_bit, smp_valid,
    output smp_en, id, rtr, dlc, data, frame_valid, frame_err
  );

  modport slave (
    output rx, smp_bit, smp_valid,
    input  smp_en, id, rtr, dlc, data, frame_valid, frame_err
  );
endinterface

// File: rtl/can_rx_frame_ctrl.sv
// CAN standard-frame receive controller: bus-idle detection, destuffing and field extraction.
// Optional macro CAN_RX_STUFF_CHECK_EN turns stuff-bit violations into frame errors.
module can_rx_frame_ctrl #(
  parameter int unsigned CLK_MHZ       = 100,
  parameter int unsigned BITRATE_KBITS = 1000
) (
  input logic               clk,
  input logic               rst_n,
  can_rx_frame_ctrl_if.master bus
);

  localparam int unsigned BT        = CLK_MHZ * 1000 / BITRATE_KBITS;
  localparam int unsigned IDLE_CLKS = 11 * BT;
  localparam int unsigned IDLE_W    = $clog2(IDLE_CLKS + 1);
  localparam int unsigned IDX_W     = 7;

  typedef enum logic [1:0] {IDLE_WAIT, IDLE, RECV, DONE} state_t;

  // Payload length in bits; remote frames carry none, DLC above 8 means 8 bytes.
  function automatic logic [IDX_W-1:0] payload_bits(input logic r, input logic [3:0] d);
    if (r)            return 7'd0;
    if (d >= 4'd8)    return 7'd64;
    return {d, 3'b000};
  endfunction

  state_t             state, state_n;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
  logic [2:0]         run_cnt, run_cnt_n;
  logic               run_val, run_val_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic               smp_en_q, smp_en_n;
  logic [10:0]        id_q, id_n;
  logic               rtr_q, rtr_n;
  logic [3:0]         dlc_q, dlc_n;
  logic [63:0]        data_q, data_n;
  logic               fv_q, fv_n;
  logic               fe_q, fe_n;
  logic               abort;
  logic               done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE_WAIT;
      idle_cnt <= '0;
      run_cnt  <= '0;
      run_val  <= 1'b0;
      bit_idx  <= '0;
      smp_en_q <= 1'b0;
      id_q     <= '0;
      rtr_q    <= 1'b0;
      dlc_q    <= '0;
      data_q   <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_cnt_n;
      run_cnt  <= run_cnt_n;
      run_val  <= run_val_n;
      bit_idx  <= bit_idx_n;
      smp_en_q <= smp_en_n;
      id_q     <= id_n;
      rtr_q    <= rtr_n;
      dlc_q    <= dlc_n;
      data_q   <= data_n;
      fv_q     <= fv_n;
      fe_q     <= fe_n;
    end
  end

  always_comb begin
    state_n    = state;
    idle_cnt_n = '0;
    run_cnt_n  = run_cnt;
    run_val_n  = run_val;
    bit_idx_n  = bit_idx;
    smp_en_n   = 1'b0;
    id_n       = id_q;
    rtr_n      = rtr_q;
    dlc_n      = dlc_q;
    data_n     = data_q;
    fv_n       = 1'b0;
    fe_n       = 1'b0;
    abort      = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE_WAIT: begin
        if (bus.rx) begin
          if (idle_cnt == IDLE_W'(IDLE_CLKS - 1)) state_n = IDLE;
          else                                    idle_cnt_n = idle_cnt + 1'b1;
        end
      end

      IDLE: begin
        if (!bus.rx) begin
          state_n   = RECV;
          smp_en_n  = 1'b1;
          run_cnt_n = '0;
          bit_idx_n = '0;
          id_n      = '0;
          rtr_n     = 1'b0;
          dlc_n     = '0;
          data_n    = '0;
        end
      end

      RECV: begin
        smp_en_n = 1'b1;
        if (bus.smp_valid) begin
          if (bit_idx == 7'd0) begin
            if (bus.smp_bit) begin
              abort = 1'b1;
            end else begin
              run_cnt_n = 3'd1;
              run_val_n = 1'b0;
              bit_idx_n = 7'd1;
            end
          end else if (run_cnt == 3'd5) begin
            // Stuff bit: dropped, but it starts the next run.
`ifdef CAN_RX_STUFF_CHECK_EN
            if (bus.smp_bit == run_val) abort = 1'b1;
`endif
            run_cnt_n = 3'd1;
            run_val_n = bus.smp_bit;
          end else begin
            run_cnt_n = (bus.smp_bit == run_val) ? run_cnt + 3'd1 : 3'd1;
            run_val_n = bus.smp_bit;
            bit_idx_n = bit_idx + 7'd1;
            if (bit_idx <= 7'd11) begin
              id_n = {id_q[9:0], bus.smp_bit};
            end else if (bit_idx == 7'd12) begin
              rtr_n = bus.smp_bit;
            end else if (bit_idx == 7'd13) begin
              if (bus.smp_bit) abort = 1'b1;
            end else if (bit_idx >= 7'd15 && bit_idx <= 7'd18) begin
              dlc_n = {dlc_q[2:0], bus.smp_bit};
              if (bit_idx == 7'd18 && payload_bits(rtr_q, dlc_n) == 7'd0) done = 1'b1;
            end else if (bit_idx >= 7'd19) begin
              data_n[6'(7'd82 - bit_idx)] = bus.smp_bit;
              if (bit_idx == 7'd18 + payload_bits(rtr_q, dlc_q)) done = 1'b1;
            end
          end

          if (abort) begin
            state_n  = IDLE_WAIT;
            smp_en_n = 1'b0;
            fe_n     = 1'b1;
          end else if (done) begin
            state_n  = DONE;
            smp_en_n = 1'b0;
            fv_n     = 1'b1;
          end
        end
      end

      DONE: begin
        state_n = IDLE_WAIT;
      end

      default: begin
        state_n = IDLE_WAIT;
      end
    endcase
  end

  assign bus.smp_en      = smp_en_q;
  assign bus.id          = id_q;
  assign bus.rtr         = rtr_q;
  assign bus.dlc         = dlc_q;
  assign bus.data        = data_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_err   = fe_q;

endmodule

// File: tb/tb_can_rx_frame_ctrl.sv
// Directed bench for can_rx_frame_ctrl: idle detection, frame decode, error and reset cases.
module tb_can_rx_frame_ctrl;
  localparam int unsigned BT = 100;

  logic clk;
  logic rst_n;
  can_rx_frame_ctrl_if bus ();

  can_rx_frame_ctrl #(.CLK_MHZ(100), .BITRATE_KBITS(1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fv_cnt, fe_cnt, both_cnt;
  logic en_seen, en_after_last;
  bit dq[$];
  bit rq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    fv_cnt = 0; fe_cnt = 0; both_cnt = 0; en_seen = 1'b0; en_after_last = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (bus.frame_valid) fv_cnt++;
    if (bus.frame_err) fe_cnt++;
    if (bus.frame_valid && bus.frame_err) both_cnt++;
    if (bus.smp_en) en_seen = 1'b1;
  endtask

  // Recessive for n clocks, then dominant (SOF level on the wire).
  task automatic go_idle(input int n);
    bus.rx = 1'b1;
    repeat (n) tick();
    bus.rx = 1'b0;
  endtask

  task automatic build_frame(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                             input logic [63:0] fdata);
    int n;
    dq.delete();
    dq.push_back(1'b0);
    for (int i = 10; i >= 0; i--) dq.push_back(fid[i]);
    dq.push_back(frtr);
    dq.push_back(1'b0);
    dq.push_back(1'b0);
    for (int i = 3; i >= 0; i--) dq.push_back(fdlc[i]);
    n = frtr ? 0 : ((fdlc > 4'd8) ? 64 : 8 * int'(fdlc));
    for (int i = 0; i < n; i++) dq.push_back(fdata[63-i]);
  endtask

  // Bit-stuff dq from index start; a stuff bit only precedes a following bit.
  task automatic stuff(input int start, input int run0, input bit val0);
    int run;
    bit val;
    run = run0; val = val0;
    rq.delete();
    for (int k = start; k < dq.size(); k++) begin
      if (run == 5) begin
        rq.push_back(!val);
        val = !val;
        run = 1;
      end
      rq.push_back(dq[k]);
      if (run > 0 && dq[k] == val) run++;
      else begin run = 1; val = dq[k]; end
    end
  endtask

  task automatic send_raw(input int nbits);
    for (int k = 0; k < nbits; k++) begin
      bus.smp_bit = rq[k];
      bus.rx = rq[k];
      bus.smp_valid = 1'b1;
      tick();
      en_after_last = bus.smp_en;
      bus.smp_valid = 1'b0;
      tick();
      tick();
    end
    bus.rx = 1'b1;
  endtask

  task automatic run_frame(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                           input logic [63:0] fdata);
    clear_mon();
    go_idle(11 * BT);
    tick();
    build_frame(fid, frtr, fdlc, fdata);
    stuff(0, 0, 1'b0);
    send_raw(rq.size());
    repeat (4) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.rx = 1'b0;
    bus.smp_bit = 1'b0;
    bus.smp_valid = 1'b0;
    clear_mon();
    #23;
    check("rst_smp_en", bus.smp_en, 0);
    check("rst_id", bus.id, 0);
    check("rst_rtr", bus.rtr, 0);
    check("rst_dlc", bus.dlc, 0);
    check("rst_data", bus.data, 0);
    check("rst_fv", bus.frame_valid, 0);
    check("rst_fe", bus.frame_err, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Idle-detection boundaries
    clear_mon();
    go_idle(10 * BT);
    repeat (3) tick();
    check("idle_10bt_no_en", en_seen, 0);
    clear_mon();
    go_idle(11 * BT - 1);
    repeat (3) tick();
    check("idle_11bt_m1_no_en", en_seen, 0);
    go_idle(11 * BT);
    check("idle_11bt_en_before", bus.smp_en, 0);
    tick();
    check("idle_11bt_en_after", bus.smp_en, 1);

    // id=0x123, dlc=1, data A5 (already in RECV)
    clear_mon();
    build_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
    stuff(0, 0, 1'b0);
    send_raw(rq.size());
    check("f123_en_after_last", en_after_last, 0);
    repeat (4) tick();
    check("f123_fv_cnt", fv_cnt, 1);
    check("f123_fe_cnt", fe_cnt, 0);
    check("f123_id", bus.id, 11'h123);
    check("f123_rtr", bus.rtr, 0);
    check("f123_dlc", bus.dlc, 1);
    check("f123_data", bus.data, 64'hA500_0000_0000_0000);

    // All-dominant header, heavy stuffing
    run_frame(11'h000, 1'b0, 4'd0, 64'h0);
    check("f000_fv_cnt", fv_cnt, 1);
    check("f000_fe_cnt", fe_cnt, 0);
    check("f000_id", bus.id, 0);
    check("f000_dlc", bus.dlc, 0);
    check("f000_data", bus.data, 0);

    // Remote frame ends right after DLC
    run_frame(11'h7FF, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rtr_en_after_dlc", en_after_last, 0);
    check("rtr_fv_cnt", fv_cnt, 1);
    check("rtr_id", bus.id, 11'h7FF);
    check("rtr_rtr", bus.rtr, 1);
    check("rtr_dlc", bus.dlc, 8);
    check("rtr_data", bus.data, 0);

    // DLC above 8 loads 8 bytes, raw DLC kept
    run_frame(11'h0F0, 1'b0, 4'hC, 64'h0123_4567_89AB_CDEF);
    check("dlc12_fv_cnt", fv_cnt, 1);
    check("dlc12_dlc", bus.dlc, 4'hC);
    check("dlc12_data", bus.data, 64'h0123_4567_89AB_CDEF);

    // Short payload after a full one: upper bytes only, rest cleared
    run_frame(11'h555, 1'b0, 4'd2, 64'hBEEF_0000_0000_0000);
    check("dlc2_id", bus.id, 11'h555);
    check("dlc2_data", bus.data, 64'hBEEF_0000_0000_0000);
    check("dlc2_fe_cnt", fe_cnt, 0);

    // SOF sampled recessive
    clear_mon();
    go_idle(11 * BT);
    tick();
    rq.delete();
    rq.push_back(1'b1);
    send_raw(1);
    repeat (3) tick();
    check("sof1_fe_cnt", fe_cnt, 1);
    check("sof1_fv_cnt", fv_cnt, 0);
    check("sof1_en", bus.smp_en, 0);

    // IDE recessive
    clear_mon();
    go_idle(11 * BT);
    tick();
    build_frame(11'h321, 1'b0, 4'd1, 64'h5A00_0000_0000_0000);
    dq[13] = 1'b1;
    stuff(0, 0, 1'b0);
    send_raw(rq.size());
    repeat (3) tick();
    check("ide_fe_cnt", fe_cnt, 1);
    check("ide_fv_cnt", fv_cnt, 0);
    check("ide_en", bus.smp_en, 0);

    // Six dominant raw bits from SOF: stuff bit equal to the run
    clear_mon();
    go_idle(11 * BT);
    tick();
    build_frame(11'h000, 1'b0, 4'd0, 64'h0);
    rq.delete();
    repeat (6) rq.push_back(1'b0);
    send_raw(6);
`ifdef CAN_RX_STUFF_CHECK_EN
    check("stuff6_fe_cnt", fe_cnt, 1);
    check("stuff6_en", bus.smp_en, 0);
`else
    check("stuff6_fe_cnt", fe_cnt, 0);
    check("stuff6_en", bus.smp_en, 1);
    stuff(5, 1, 1'b0);
    send_raw(rq.size());
    repeat (4) tick();
    check("stuff6_fv_cnt", fv_cnt, 1);
    check("stuff6_fe_final", fe_cnt, 0);
    check("stuff6_id", bus.id, 0);
`endif

    // Reset during data bits
    clear_mon();
    go_idle(11 * BT);
    tick();
    build_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
    stuff(0, 0, 1'b0);
    send_raw(rq.size() - 4);
    check("mid_id_loaded", bus.id, 11'h123);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", bus.smp_en, 0);
    check("mid_rst_id", bus.id, 0);
    check("mid_rst_dlc", bus.dlc, 0);
    check("mid_rst_data", bus.data, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("mid_rst_no_fv", fv_cnt, 0);
    check("mid_rst_no_fe", fe_cnt, 0);
    run_frame(11'h123, 1'b0, 4'd1, 64'hA500_0000_0000_0000);
    check("post_rst_fv_cnt", fv_cnt, 1);
    check("post_rst_id", bus.id, 11'h123);
    check("post_rst_data", bus.data, 64'hA500_0000_0000_0000);

    check("never_fv_and_fe", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/can_rx_frame_ctrl.md
CAN_RX_FRAME_CTRL -- requirements
Module: can_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 100: system clock frequency in MHz.
REQ-002 SHALL have parameter BITRATE_KBITS, default 1000: CAN bit rate in kbit/s; bit period in clocks BT = CLK_MHZ*1000/BITRATE_KBITS.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx  input  1  raw CAN bus level, 1 = recessive, pre-synchronised.
REQ-006 SHALL have port smp_en  output  1  enable to the bit sampler.
REQ-007 SHALL have port smp_bit  input  1  sampled bit from the sampler.
REQ-008 SHALL have port smp_valid  input  1  one-cycle strobe qualifying smp_bit.
REQ-009 SHALL have port id  output  11  received standard identifier.
REQ-010 SHALL have port rtr  output  1  received RTR bit.
REQ-011 SHALL have port dlc  output  4  received DLC, raw value.
REQ-012 SHALL have port data  output  64  payload, first received byte in data[63:56], MSB first.
REQ-013 SHALL have port frame_valid  output  1  one-cycle pulse, fields complete.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse, frame aborted (stuff or format error).

Function
REQ-015 SHALL implement states IDLE_WAIT, IDLE, RECV, DONE.
REQ-016 IDLE_WAIT SHALL count clocks with rx=1; any rx=0 clears the count; at 11*BT consecutive recessive clocks go to IDLE.
REQ-017 IDLE SHALL, on the first clock with rx=0, assert smp_en in the next cycle and enter RECV; smp_en SHALL be 0 in all other states.
REQ-018 RECV SHALL treat the first smp_valid bit as SOF (destuffed index 0); SOF=1 SHALL pulse frame_err and go to IDLE_WAIT.
REQ-019 Destuffing: SHALL keep a run counter (1..5) of equal consecutive raw bits starting with SOF; the raw bit following a run of 5 is a stuff bit, SHALL be discarded, and SHALL restart the run at 1 with its own value.
REQ-020 Destuffed indices SHALL map: 1-11 id (MSB first), 12 rtr, 13 IDE, 14 r0, 15-18 dlc (MSB first), 19.. data.
REQ-021 IDE=1 SHALL pulse frame_err at that bit and go to IDLE_WAIT; r0 value SHALL be ignored.
REQ-022 Payload length SHALL be 0 bits if rtr=1, else 8*min(dlc,8); DLC 9-15 SHALL load 8 bytes while dlc output holds the raw value.
REQ-023 Unreceived data bytes SHALL read 0; data SHALL be cleared on entry to RECV.
REQ-024 After the last DLC bit (zero payload) or last data bit, SHALL enter DONE, deasserting smp_en on the next clock; the CRC field is not consumed.
REQ-025 DONE SHALL pulse frame_valid for exactly one cycle then go to IDLE_WAIT.
REQ-026 id, rtr, dlc, data SHALL be held stable from the frame_valid pulse until the next entry to RECV.
REQ-027 smp_valid outside RECV SHALL be ignored; frame_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state IDLE_WAIT, idle counter 0, run counter 0, smp_en=0, id=0, rtr=0, dlc=0, data=0, frame_valid=0, frame_err=0.
REQ-029 Reset asserted mid-RECV SHALL discard the partial frame with no frame_valid or frame_err pulse.

Configuration
REQ-030 With macro CAN_RX_STUFF_CHECK_EN defined, a stuff bit equal to the preceding run value SHALL pulse frame_err and return to IDLE_WAIT.
REQ-031 Without CAN_RX_STUFF_CHECK_EN, stuff bits SHALL be discarded unchecked and frame_err SHALL assert only for SOF/IDE errors.

Verification
REQ-032 rx=1 for 10*BT then 0 -> smp_en stays 0; rx=1 for 11*BT then 0 -> smp_en=1 one clock later.
REQ-033 Frame id=0x123, rtr=0, dlc=1, data byte 0xA5, correctly stuffed -> one frame_valid, id=0x123, dlc=1, data=0xA500_0000_0000_0000, smp_en=0 after last data bit.
REQ-034 id=0x000, dlc=0 (stuff bits after SOF+4 id zeros, etc.) -> frame_valid, id=0x000, dlc=0, data=0, no frame_err.
REQ-035 Remote frame id=0x7FF, rtr=1, dlc=8 -> frame_valid right after DLC, data=0, dlc=8.
REQ-036 Six consecutive dominant raw bits after SOF -> with CAN_RX_STUFF_CHECK_EN frame_err pulse and smp_en=0; without, decoding continues.
REQ-037 rst_n pulsed low during data bits -> all outputs 0 immediately, no pulses, next valid frame after 11*BT idle decodes correctly.
